// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-client ALU arbiter/sequencer.
// State encoding, ALU control codes and the grant-counter width live here.
`timescale 1ns/1ps
package alu_arb_pkg;

  localparam int GRANT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // ALU control codes understood by the shared ALU; the arbiter passes them through.
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

endpackage

// File: rtl/alu_arb_rr.sv
// Combinational 2-way round-robin picker: ptr selects the favoured client
// when both request; a lone requester always wins.
`timescale 1ns/1ps
module alu_arb_rr (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       pick,
  output logic       any
);

  always_comb begin
    any  = |valid;
    pick = (valid == 2'b11) ? ptr : valid[1];
  end

endmodule

// File: rtl/alu_share_arb.sv
// Arbiter and sequencer for one shared combinational ALU serving two clients.
// Optional grant statistics are enabled with the ALU_ARB_STATS_EN macro.
//
// Handshakes: a request transfers on an edge where req_valid[i] && req_ready[i];
// a response transfers on an edge where resp_valid[i] && resp_ready[i]. Valid
// may be dropped before acceptance; ready never depends on the client's ready.
`timescale 1ns/1ps
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [ALUC_W-1:0] req_aluc0,
  input  logic [ALUC_W-1:0] req_aluc1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_s,
  output logic              resp_z,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ALUC_W-1:0] alu_aluc,
  input  logic [DATA_W-1:0] alu_s,
  input  logic              alu_z,
  output logic              busy,
  output logic [1:0]        dbg_state
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [GRANT_CNT_W-1:0] grant_cnt0,
  output logic [GRANT_CNT_W-1:0] grant_cnt1
`endif
);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               gnt_q, gnt_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
  logic [ALUC_W-1:0]  aluc_q, aluc_d;
  logic               z_q, z_d;
  logic               pick, any, accept;

  alu_arb_rr u_rr (
    .valid (req_valid),
    .ptr   (ptr_q),
    .pick  (pick),
    .any   (any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    a_d        = a_q;
    b_d        = b_q;
    aluc_d     = aluc_q;
    s_d        = s_q;
    z_d        = z_q;
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        // Gating with resetn keeps req_ready low while reset is held.
        if (any && resetn) begin
          req_ready[pick] = 1'b1;
          accept          = 1'b1;
          gnt_d           = pick;
          a_d             = pick ? req_a1 : req_a0;
          b_d             = pick ? req_b1 : req_b0;
          aluc_d          = pick ? req_aluc1 : req_aluc0;
          state_d         = EXEC;
        end
      end
      EXEC: begin
        s_d     = alu_s;
        z_d     = alu_z;
        state_d = RESP;
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) begin
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
      s_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      s_q     <= s_d;
      z_q     <= z_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_aluc  = aluc_q;
  assign resp_s    = s_q;
  assign resp_z    = z_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

`ifdef ALU_ARB_STATS_EN
  logic [GRANT_CNT_W-1:0] cnt0_q, cnt1_q;

  // Clear wins over a same-cycle accept; counts saturate instead of wrapping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (stats_clr) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (!pick && (cnt0_q != '1)) cnt0_q <= cnt0_q + GRANT_CNT_W'(1);
      if (pick && (cnt1_q != '1))  cnt1_q <= cnt1_q + GRANT_CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a behavioural ALU and a
// transaction-level reference model; stats checks build with ALU_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [DW-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [CW-1:0] req_aluc0 = '0, req_aluc1 = '0;
  logic [DW-1:0] resp_s, alu_a, alu_b, alu_s;
  logic [CW-1:0] alu_aluc;
  logic          resp_z, alu_z, busy;
  logic [1:0]    dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  alu_share_arb dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_aluc0  (req_aluc0),
    .req_aluc1  (req_aluc1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_s     (resp_s),
    .resp_z     (resp_z),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_aluc   (alu_aluc),
    .alu_s      (alu_s),
    .alu_z      (alu_z),
    .busy       (busy),
    .dbg_state  (dbg_state)
`ifdef ALU_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Shared ALU behaviour: shifts move b by a[4:0]; LUI places b[15:0] high.
  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
    logic signed [DW-1:0] bs;
    bs = b;
    case (c)
      ALUC_ADD: return a + b;
      ALUC_SUB: return a - b;
      ALUC_AND: return a & b;
      ALUC_OR:  return a | b;
      ALUC_XOR: return a ^ b;
      ALUC_LUI: return {b[15:0], 16'h0000};
      ALUC_SLL: return b << a[4:0];
      ALUC_SRL: return b >> a[4:0];
      ALUC_SRA: return bs >>> a[4:0];
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    alu_s = alu_ref(alu_a, alu_b, alu_aluc);
    alu_z = (alu_s == '0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] op);
    if (c == 0) begin
      req_a0 = a; req_b0 = b; req_aluc0 = op; req_valid[0] = 1'b1;
    end else begin
      req_a1 = a; req_b1 = b; req_aluc1 = op; req_valid[1] = 1'b1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0;
    resp_ready = '0;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    model_ptr = 0;
    exp_q.delete();
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (resp_valid != 2'b00) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // One complete transaction from a lone requester, response taken at once.
  task automatic run_txn(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] op, output bit ok);
    set_req(c, a, b, op);
    tick();
    req_valid[c] = 1'b0;
    resp_ready = 2'b11;
    wait_resp(ok);
    tick();
    resp_ready = 2'b00;
    if (ok) model_ptr = (c == 0) ? 1 : 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok;
    do_reset();
    checks++;
    if ({req_ready, resp_valid, resp_s, resp_z, alu_a, alu_b, alu_aluc, busy} !== '0) begin
      failures++;
      $display("FAIL reset_idle_outputs: rr=%b rv=%b s=%h z=%b a=%h b=%h c=%h busy=%b required all 0",
               req_ready, resp_valid, resp_s, resp_z, alu_a, alu_b, alu_aluc, busy);
    end
    run_txn(0, 32'd10, 32'd20, ALUC_ADD, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_pre_txn: no response, required one"); end
    set_req(1, 32'h1234, 32'h5678, ALUC_XOR);
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_pre_exec_busy: got %b required 1", busy); end
    resetn = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_s, resp_z, alu_a, alu_b, alu_aluc, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid_exec_outputs: rr=%b rv=%b s=%h z=%b a=%h b=%h c=%h busy=%b required all 0",
               req_ready, resp_valid, resp_s, resp_z, alu_a, alu_b, alu_aluc, busy);
    end
    tick();
    req_valid = 2'b00;
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (resp_valid !== 2'b00) begin
        failures++;
        $display("FAIL reset_no_resp: cycle %0d got %b required 00", k, resp_valid);
      end
    end
    set_req(0, 32'd1, 32'd1, ALUC_ADD);
    set_req(1, 32'd2, 32'd2, ALUC_ADD);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL reset_ptr_zero: req_ready got %b required 01", req_ready);
    end
    req_valid = 2'b00;
    tick();
    model_ptr = 0;
  endtask

  task automatic test_single_op();
    do_reset();
    set_req(0, 32'd5, 32'd3, ALUC_ADD);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready: got %b required 01", req_ready); end
    tick();
    req_valid = 2'b00;
    resp_ready = 2'b01;
    checks++;
    if ({alu_a, alu_b, alu_aluc} !== {32'd5, 32'd3, ALUC_ADD}) begin
      failures++;
      $display("FAIL single_alu_ports: a=%h b=%h c=%h required 5 3 0", alu_a, alu_b, alu_aluc);
    end
    checks++;
    if ({busy, req_ready, resp_valid} !== {1'b1, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL single_exec: busy=%b rr=%b rv=%b required 1 00 00", busy, req_ready, resp_valid);
    end
    tick();
    checks++;
    if ({resp_valid, resp_s, resp_z} !== {2'b01, 32'd8, 1'b0}) begin
      failures++;
      $display("FAIL single_resp: rv=%b s=%h z=%b required 01 8 0", resp_valid, resp_s, resp_z);
    end
    tick();
    checks++;
    if ({busy, resp_valid} !== {1'b0, 2'b00}) begin
      failures++;
      $display("FAIL single_done: busy=%b rv=%b required 0 00", busy, resp_valid);
    end
    resp_ready = 2'b00;
    model_ptr = 1;
  endtask

  task automatic test_contention();
    bit ok;
    int win;
    logic [DW-1:0] exp_s;
    do_reset();
    set_req(0, 32'd7, 32'd7, ALUC_SUB);
    set_req(1, 32'd4, 32'h8000_0000, ALUC_SRA);
    resp_ready = 2'b11;
    for (int t = 0; t < 3; t++) begin
      win = model_ptr;
      exp_s = (win == 0) ? 32'h0000_0000 : 32'hF800_0000;
      wait_resp(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL contention_timeout: op %0d no response", t); end
      checks++;
      if (resp_valid !== ((win == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL contention_order: op %0d resp_valid=%b required client %0d", t, resp_valid, win);
      end
      checks++;
      if ({resp_s, resp_z} !== {exp_s, (win == 0)}) begin
        failures++;
        $display("FAIL contention_data: op %0d s=%h z=%b required %h %b", t, resp_s, resp_z,
                 exp_s, (win == 0));
      end
      tick();
      model_ptr = 1 - win;
    end
    req_valid = 2'b00;
    resp_ready = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, exp_s;
    do_reset();
    a = $urandom;
    b = $urandom;
    exp_s = alu_ref(a, b, ALUC_XOR);
    set_req(1, a, b, ALUC_XOR);
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 32'd9, 32'd9, ALUC_ADD);
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({resp_valid, resp_s, req_ready} !== {2'b10, exp_s, 2'b00}) begin
        failures++;
        $display("FAIL backpressure_hold: cycle %0d rv=%b s=%h rr=%b required 10 %h 00",
                 k, resp_valid, resp_s, req_ready, exp_s);
      end
      tick();
    end
    resp_ready = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL backpressure_handshake_ready: got %b required 00", req_ready);
    end
    tick();
    checks++;
    if ({busy, req_ready} !== {1'b0, 2'b01}) begin
      failures++;
      $display("FAIL backpressure_next_accept: busy=%b rr=%b required 0 01", busy, req_ready);
    end
    req_valid = 2'b00;
    resp_ready = 2'b00;
    tick();
  endtask

  task automatic test_wrong_ready();
    do_reset();
    set_req(0, 32'hF0F0, 32'h0FF0, ALUC_AND);
    tick();
    req_valid = 2'b00;
    resp_ready = 2'b10;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({resp_valid, busy, resp_s} !== {2'b01, 1'b1, 32'h0000_00F0}) begin
        failures++;
        $display("FAIL wrong_ready_hold: cycle %0d rv=%b busy=%b s=%h required 01 1 000000f0",
                 k, resp_valid, busy, resp_s);
      end
      tick();
    end
    resp_ready = 2'b01;
    tick();
    checks++;
    if ({busy, resp_valid} !== {1'b0, 2'b00}) begin
      failures++;
      $display("FAIL wrong_ready_complete: busy=%b rv=%b required 0 00", busy, resp_valid);
    end
    resp_ready = 2'b00;
  endtask

  // Cycle-level comparison against a transaction model: one op in flight,
  // response visible two cycles after acceptance, ptr flips on completion.
  task automatic test_random();
    bit inflight;
    int age, gnt, pick;
    logic [1:0] exp_ready, exp_rv;
    logic [DW-1:0] ra[2], rb[2], ea, eb;
    logic [CW-1:0] rc[2];
    do_reset();
    inflight = 1'b0;
    age = 0;
    gnt = 0;
    ea = '0;
    eb = '0;
    for (int c = 0; c < 2; c++) begin ra[c] = '0; rb[c] = '0; rc[c] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (inflight) age++;
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 3) != 0) begin
          ra[c] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
          rb[c] = ($urandom_range(0, 3) == 0) ? ra[c] : $urandom;
          rc[c] = 4'($urandom_range(0, 15));
          set_req(c, ra[c], rb[c], rc[c]);
          req_valid[c] = 1'($urandom_range(0, 1));
        end
      end
      resp_ready = 2'($urandom_range(0, 3));
      #1;
      exp_ready = 2'b00;
      pick = (req_valid == 2'b11) ? model_ptr : (req_valid[1] ? 1 : 0);
      if (!inflight && req_valid != 2'b00) exp_ready[pick] = 1'b1;
      exp_rv = 2'b00;
      if (inflight && age >= 2) exp_rv[gnt] = 1'b1;
      checks++;
      if ({req_ready, resp_valid, busy} !== {exp_ready, exp_rv, inflight}) begin
        failures++;
        $display("FAIL random_ctrl: cycle %0d rr=%b rv=%b busy=%b required %b %b %b",
                 cyc, req_ready, resp_valid, busy, exp_ready, exp_rv, inflight);
      end
      if (inflight) begin
        checks++;
        if ({alu_a, alu_b} !== {ea, eb}) begin
          failures++;
          $display("FAIL random_alu_ports: cycle %0d a=%h b=%h required %h %h", cyc, alu_a, alu_b, ea, eb);
        end
      end
      if (exp_rv != 2'b00 && exp_q.size() > 0) begin
        checks++;
        if ({resp_s, resp_z} !== {exp_q[0], (exp_q[0] == '0)}) begin
          failures++;
          $display("FAIL random_data: cycle %0d s=%h z=%b required %h %b", cyc, resp_s, resp_z,
                   exp_q[0], (exp_q[0] == '0));
        end
      end
      if (!inflight && req_valid != 2'b00) begin
        exp_q.push_back(alu_ref(ra[pick], rb[pick], rc[pick]));
        ea = ra[pick];
        eb = rb[pick];
        gnt = pick;
        inflight = 1'b1;
        age = 0;
      end else if (exp_rv != 2'b00 && resp_ready[gnt]) begin
        void'(exp_q.pop_front());
        model_ptr = 1 - gnt;
        inflight = 1'b0;
      end
      tick();
    end
    req_valid = 2'b00;
    resp_ready = 2'b00;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_txn(1, 32'(k), 32'd1, ALUC_ADD, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL stats_txn: op %0d no response", k); end
    end
    checks++;
    if ({grant_cnt0, grant_cnt1} !== {16'd0, 16'd3}) begin
      failures++;
      $display("FAIL stats_count: cnt0=%0d cnt1=%0d required 0 3", grant_cnt0, grant_cnt1);
    end
    set_req(1, 32'd2, 32'd2, ALUC_OR);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    req_valid = 2'b00;
    checks++;
    if ({busy, grant_cnt1} !== {1'b1, 16'd0}) begin
      failures++;
      $display("FAIL stats_clr_priority: busy=%b cnt1=%0d required 1 0", busy, grant_cnt1);
    end
    resp_ready = 2'b11;
    wait_resp(ok);
    tick();
    resp_ready = 2'b00;
    run_txn(0, 32'd1, 32'd1, ALUC_ADD, ok);
    checks++;
    if ({grant_cnt0, grant_cnt1} !== {16'd1, 16'd0}) begin
      failures++;
      $display("FAIL stats_after_clr: cnt0=%0d cnt1=%0d required 1 0", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_wrong_ready();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU. It accepts operation requests (a, b, aluc) from two clients, for example the CPU execute path and a debug/IO engine. It grants one request at a time by round-robin, drives the ALU input ports from registered operands, captures s/z, and returns the result to the granted client over a valid/ready response handshake. It sits between the clients and the single ALU instance; the ALU itself is external.

## Interface
- DATA_W, 32: operand/result width
- ALUC_W, 4: ALU control code width
- clock  in  1  single clock, rising edge
- resetn  in  1  reset; asynchronous and active-low
- req_valid  in  2  per-client request valid, bit i = client i
- req_ready  out  2  per-client accept; at most one bit set
- req_a0, req_b0 / req_a1, req_b1  in  DATA_W  operands per client
- req_aluc0 / req_aluc1  in  ALUC_W  ALU code per client
- resp_valid  out  2  result valid to client i, at most one bit set
- resp_ready  in  2  client i takes result
- resp_s  out  DATA_W  registered result
- resp_z  out  1  registered zero flag
- alu_a, alu_b  out  DATA_W  to ALU a/b
- alu_aluc  out  ALUC_W  to ALU aluc
- alu_s  in  DATA_W  from ALU s
- alu_z  in  1  from ALU z
- busy  out  1  high in any state other than IDLE

## Operation
- FSM has three states: IDLE, EXEC, RESP. Only one transaction is in flight at a time.
- IDLE
  - pick = round-robin choice among the set req_valid bits.
  - req_ready[pick] is asserted combinationally.
  - On valid&ready the block latches a, b, aluc and gnt=pick, then goes to EXEC.
  - No valid: stay in IDLE; req_ready=0.
- EXEC
  - alu_a/alu_b/alu_aluc carry the latched operands; this holds in all states.
  - alu_s and alu_z are captured into resp_s/resp_z. Next state is RESP.
- RESP
  - resp_valid[gnt]=1; resp_s/resp_z are held stable.
  - On resp_ready[gnt]: priority pointer ptr becomes ~gnt, then IDLE.
  - resp_ready of the non-granted client is ignored.
- Round-robin:
  - ptr=0 favours client 0, ptr=1 favours client 1.
  - With a single requester, that requester wins regardless of ptr.
  - ptr updates only on response completion.
- aluc is passed through unchecked. Undefined codes yield whatever the ALU gives (0, z=1).
- A requester may drop or change req_valid/operands before acceptance without effect. Operands are only sampled on the accept cycle.
- Reset, at any time including mid-transaction:
  - State IDLE, ptr=0, gnt=0.
  - Operand registers, resp_s, and alu_* = 0; resp_z=0.
  - req_ready=0 during reset; all other outputs 0.
  - An in-flight transaction is discarded with no response.

## Timing
- Accept in cycle T (valid&ready high at edge T). ALU is driven with new operands from T+1 (EXEC). resp_valid rises at T+2.
- Minimum occupancy is 3 cycles per op (accept, exec, response taken the same cycle resp_valid rises). Maximum throughput is one op per 3 cycles.
- Response is held indefinitely until resp_ready; no new accept occurs during EXEC/RESP (req_ready=0).
- A new request can be accepted in the cycle after the response handshake (IDLE), not in the same cycle.
- Simultaneous req_valid=2'b11 in IDLE grants per ptr; the loser keeps waiting with no loss.

## Configuration
- ALU_ARB_STATS_EN
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1 (16 bits each). Each counts accepted requests per client, saturating at 16'hFFFF.
  - Adds input stats_clr (1 bit), which zeroes both counters synchronously and takes priority over an increment in the same cycle.
  - Counters reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package alu_arb_pkg holds:
  - State enum (IDLE, EXEC, RESP).
  - ALU code constants: ADD 4'b0000, SUB 4'b0100, AND 4'b0001, OR 4'b0101, XOR 4'b0010, LUI 4'b0110, SLL 4'b0011, SRL 4'b0111, SRA 4'b1111.
  - Counter width constant (16).
- One sub-module, alu_arb_rr: combinational 2-way round-robin picker (valid[1:0], ptr → pick, any).

## Test plan
- Reset: resetn low mid-EXEC. All outputs 0, no resp_valid after release, and the next request is served by client 0 with ptr=0.
- Single op: client 0 ADD a=5, b=3 accepted at T. alu_a=5 from T+1; resp_valid=2'b01, resp_s=8, resp_z=0 at T+2.
- Contention: both valid continuously. Client 0 SUB 7-7 is granted first (resp_s=0, resp_z=1), then client 1 SRA a=4, b=32'h80000000 (resp_s=32'hF8000000), then client 0 again.
- Backpressure: resp_ready held low 5 cycles. resp_valid and resp_s stay stable; req_ready stays 0 throughout.
- Wrong-client ready: resp_ready=2'b10 while gnt=0 gives no completion; state stays RESP.
- Stats (macro defined): 3 grants to client 1, then stats_clr asserted in the same cycle as a 4th accept. grant_cnt1=0 after that edge.
